// File: rtl/wb_stage_lsx_pkg.sv
// Shared constants and types for the write-back stage.
package wb_pkg;
  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, DRAIN} wb_state_e;
endpackage

// File: rtl/wb_stage_lsx_if.sv
// MEM->WB handshake, data-memory response and register-file/forwarding bus.
interface wb_stage_lsx_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              mem_valid;
  logic              mem_ready;
  logic [1:0]        mem_wb_sel;
  logic              mem_reg_write;
  logic [REG_AW-1:0] mem_rd_addr;
  logic [XLEN-1:0]   mem_alu_result;
  logic [XLEN-1:0]   mem_pc_plus4;
  logic [2:0]        mem_funct3;
  logic              dmem_rvalid;
  logic [XLEN-1:0]   dmem_rdata;
  logic              flush;
  logic              wb_valid;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd_addr;
  logic [XLEN-1:0]   wb_rd_data;
  logic              wb_misalign;
  logic              wb_spurious;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output mem_valid, mem_wb_sel, mem_reg_write, mem_rd_addr, mem_alu_result,
           mem_pc_plus4, mem_funct3, dmem_rvalid, dmem_rdata, flush,
    input  mem_ready, wb_valid, wb_reg_write, wb_rd_addr, wb_rd_data,
           wb_misalign, wb_spurious, retire_cnt
  );

  modport slave (
    input  mem_valid, mem_wb_sel, mem_reg_write, mem_rd_addr, mem_alu_result,
           mem_pc_plus4, mem_funct3, dmem_rvalid, dmem_rdata, flush,
    output mem_ready, wb_valid, wb_reg_write, wb_rd_addr, wb_rd_data,
           wb_misalign, wb_spurious, retire_cnt
  );
endinterface

// File: rtl/wb_stage_lsx_load_align.sv
// Combinational load aligner: lane select, sign/zero extension, misalign check.
module load_align
  import wb_pkg::*;
#(
  parameter int  XLEN  = 32,
  localparam int LSB_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  rdata_i,
  input  logic [LSB_W-1:0] lsb_i,
  input  logic [2:0]       funct3_i,
  output logic [XLEN-1:0]  data_o,
  output logic             misalign_o
);
  logic [2:0]      f3;
  logic [2:0]      off;
  logic [XLEN-1:0] shifted;

  // Fold illegal encodings onto LW, shift the addressed lane down, then extend.
  always_comb begin
    f3 = funct3_i;
    if (f3 == 3'b111) f3 = F3_LW;
    if (XLEN == 32 && (f3 == F3_LD || f3 == F3_LWU)) f3 = F3_LW;
    off        = 3'(lsb_i);
    shifted    = rdata_i >> {lsb_i, 3'b000};
    data_o     = shifted;
    misalign_o = 1'b0;
    case (f3)
      F3_LB:  data_o = XLEN'($signed(shifted[7:0]));
      F3_LBU: data_o = XLEN'(shifted[7:0]);
      F3_LH:  begin data_o = XLEN'($signed(shifted[15:0])); misalign_o = off[0]; end
      F3_LHU: begin data_o = XLEN'(shifted[15:0]);          misalign_o = off[0]; end
      F3_LW:  begin data_o = XLEN'($signed(shifted[31:0])); misalign_o = |off[1:0]; end
      F3_LWU: begin data_o = XLEN'(shifted[31:0]);          misalign_o = |off[1:0]; end
      F3_LD:  begin data_o = shifted;                       misalign_o = |off; end
      default: ;
    endcase
  end
endmodule

// File: rtl/wb_stage_lsx.sv
// Write-back stage: MEM/WB register, load-wait FSM, result select, retire counter.
module wb_stage_lsx
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input logic           clk,
  input logic           rst,
  wb_stage_lsx_if.slave bus
);
  localparam int LSB_W = $clog2(XLEN/8);

  wb_state_e         state_q, state_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_we_q, wb_we_d;
  logic              wb_mis_q, wb_mis_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              spur_q, spur_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
  logic [2:0]        ld_f3_q, ld_f3_d;
  logic [LSB_W-1:0]  ld_lsb_q, ld_lsb_d;
  logic              ld_we_q, ld_we_d;

  logic              accept, is_load;
  logic [LSB_W-1:0]  al_lsb;
  logic [2:0]        al_f3;
  logic [XLEN-1:0]   al_data;
  logic              al_mis;

  assign bus.mem_ready = (state_q == IDLE);
  assign accept        = bus.mem_valid && bus.mem_ready;
  assign is_load       = (bus.mem_wb_sel == WB_SEL_LOAD);

  // In IDLE the aligner sees the live instruction; while waiting, the latched one.
  assign al_lsb = (state_q == IDLE) ? bus.mem_alu_result[LSB_W-1:0] : ld_lsb_q;
  assign al_f3  = (state_q == IDLE) ? bus.mem_funct3 : ld_f3_q;

  load_align #(.XLEN(XLEN)) u_align (
    .rdata_i    (bus.dmem_rdata),
    .lsb_i      (al_lsb),
    .funct3_i   (al_f3),
    .data_o     (al_data),
    .misalign_o (al_mis)
  );

  // Next-state and next-output logic; write data/address hold unless retiring.
  always_comb begin
    state_d    = state_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_mis_d   = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    spur_d     = spur_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_lsb_d   = ld_lsb_q;
    ld_we_d    = ld_we_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_load && !bus.dmem_rvalid) begin
            ld_rd_d  = bus.mem_rd_addr;
            ld_f3_d  = bus.mem_funct3;
            ld_lsb_d = bus.mem_alu_result[LSB_W-1:0];
            ld_we_d  = bus.mem_reg_write;
            // A killed load still has a response in flight; swallow it.
            state_d  = bus.flush ? DRAIN : WAIT_LOAD;
          end else if (!bus.flush) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = bus.mem_rd_addr;
            wb_mis_d   = is_load && al_mis;
            wb_we_d    = bus.mem_reg_write && (bus.mem_rd_addr != '0) && !wb_mis_d;
            case (bus.mem_wb_sel)
              WB_SEL_LOAD: wb_data_d = al_data;
              WB_SEL_PC4:  wb_data_d = bus.mem_pc_plus4;
              default:     wb_data_d = bus.mem_alu_result;
            endcase
          end
        end else if (bus.dmem_rvalid) begin
          spur_d = 1'b1;
        end
      end
      WAIT_LOAD: begin
        if (bus.dmem_rvalid) begin
          state_d = IDLE;
          if (!bus.flush) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ld_rd_q;
            wb_mis_d   = al_mis;
            wb_we_d    = ld_we_q && (ld_rd_q != '0) && !al_mis;
            wb_data_d  = al_data;
          end
        end else if (bus.flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   if (bus.dmem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = cnt_q + CNT_W'(wb_valid_d);
  end

  // State, outputs and load latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_mis_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      spur_q     <= 1'b0;
      cnt_q      <= '0;
      ld_rd_q    <= '0;
      ld_f3_q    <= '0;
      ld_lsb_q   <= '0;
      ld_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_mis_q   <= wb_mis_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      spur_q     <= spur_d;
      cnt_q      <= cnt_d;
      ld_rd_q    <= ld_rd_d;
      ld_f3_q    <= ld_f3_d;
      ld_lsb_q   <= ld_lsb_d;
      ld_we_q    <= ld_we_d;
    end
  end

  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_reg_write = wb_we_q;
  assign bus.wb_misalign  = wb_mis_q;
  assign bus.wb_rd_addr   = wb_rd_q;
  assign bus.wb_rd_data   = wb_data_q;
  assign bus.wb_spurious  = spur_q;
  assign bus.retire_cnt   = cnt_q;
endmodule

// File: tb/tb_wb_stage_lsx.sv
// Directed bench for wb_stage_lsx: 32-bit instance for the main flow, 64-bit for wide loads.
module tb_wb_stage_lsx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_stage_lsx_if #(.XLEN(32), .REG_AW(5), .CNT_W(32)) b32 ();
  wb_stage_lsx_if #(.XLEN(64), .REG_AW(5), .CNT_W(32)) b64 ();

  wb_stage_lsx #(.XLEN(32), .REG_AW(5), .CNT_W(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
  wb_stage_lsx #(.XLEN(64), .REG_AW(5), .CNT_W(32)) u64 (.clk(clk), .rst(rst), .bus(b64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle32();
    b32.mem_valid = 0; b32.mem_wb_sel = 0; b32.mem_reg_write = 0; b32.mem_rd_addr = 0;
    b32.mem_alu_result = 0; b32.mem_pc_plus4 = 0; b32.mem_funct3 = 0;
    b32.dmem_rvalid = 0; b32.dmem_rdata = 0; b32.flush = 0;
  endtask

  task automatic idle64();
    b64.mem_valid = 0; b64.mem_wb_sel = 0; b64.mem_reg_write = 0; b64.mem_rd_addr = 0;
    b64.mem_alu_result = 0; b64.mem_pc_plus4 = 0; b64.mem_funct3 = 0;
    b64.dmem_rvalid = 0; b64.dmem_rdata = 0; b64.flush = 0;
  endtask

  // Present one instruction on the 32-bit instance.
  task automatic issue32(input logic [1:0] sel, input logic we, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3,
                         input logic rv, input logic [31:0] rdata);
    b32.mem_valid = 1; b32.mem_wb_sel = sel; b32.mem_reg_write = we; b32.mem_rd_addr = rd;
    b32.mem_alu_result = alu; b32.mem_pc_plus4 = pc4; b32.mem_funct3 = f3;
    b32.dmem_rvalid = rv; b32.dmem_rdata = rdata;
  endtask

  task automatic load64(input logic [4:0] rd, input logic [63:0] alu, input logic [2:0] f3,
                        input logic [63:0] rdata);
    b64.mem_valid = 1; b64.mem_wb_sel = 2'b01; b64.mem_reg_write = 1; b64.mem_rd_addr = rd;
    b64.mem_alu_result = alu; b64.mem_funct3 = f3; b64.dmem_rvalid = 1; b64.dmem_rdata = rdata;
  endtask

  initial begin
    idle32();
    idle64();
    step();
    step();
    // Reset state
    chk("rst_valid", 64'(b32.wb_valid), 64'd0);
    chk("rst_we", 64'(b32.wb_reg_write), 64'd0);
    chk("rst_data", 64'(b32.wb_rd_data), 64'd0);
    chk("rst_cnt", 64'(b32.retire_cnt), 64'd0);
    chk("rst_spur", 64'(b32.wb_spurious), 64'd0);
    rst = 0;
    chk("ready_after_rst", 64'(b32.mem_ready), 64'd1);

    // 1: ALU result, latency 1
    issue32(2'b00, 1, 5'd5, 32'h0000_1234, 0, 0, 0, 0);
    step();
    idle32();
    chk("alu_valid", 64'(b32.wb_valid), 64'd1);
    chk("alu_we", 64'(b32.wb_reg_write), 64'd1);
    chk("alu_rd", 64'(b32.wb_rd_addr), 64'd5);
    chk("alu_data", 64'(b32.wb_rd_data), 64'h1234);
    chk("alu_cnt", 64'(b32.retire_cnt), 64'd1);

    // 2: LB / LBU lane 3, same-cycle response
    issue32(2'b01, 1, 5'd3, 32'h0000_1003, 0, 3'b000, 1, 32'h80FF_0000);
    step();
    chk("lb_data", 64'(b32.wb_rd_data), 64'hFFFF_FF80);
    chk("lb_we", 64'(b32.wb_reg_write), 64'd1);
    issue32(2'b01, 1, 5'd4, 32'h0000_1003, 0, 3'b100, 1, 32'h80FF_0000);
    step();
    idle32();
    chk("lbu_data", 64'(b32.wb_rd_data), 64'h0000_0080);
    chk("lbu_rd", 64'(b32.wb_rd_addr), 64'd4);
    chk("lbu_cnt", 64'(b32.retire_cnt), 64'd3);

    // 3: LW with response three cycles late
    issue32(2'b01, 1, 5'd7, 32'h0000_2000, 0, 3'b010, 0, 0);
    step();
    idle32();
    chk("lw_wait_ready1", 64'(b32.mem_ready), 64'd0);
    chk("lw_wait_valid", 64'(b32.wb_valid), 64'd0);
    chk("lw_wait_hold", 64'(b32.wb_rd_data), 64'h80);
    step();
    chk("lw_wait_ready2", 64'(b32.mem_ready), 64'd0);
    step();
    chk("lw_wait_ready3", 64'(b32.mem_ready), 64'd0);
    b32.dmem_rvalid = 1; b32.dmem_rdata = 32'hDEAD_BEEF;
    step();
    idle32();
    chk("lw_valid", 64'(b32.wb_valid), 64'd1);
    chk("lw_we", 64'(b32.wb_reg_write), 64'd1);
    chk("lw_rd", 64'(b32.wb_rd_addr), 64'd7);
    chk("lw_data", 64'(b32.wb_rd_data), 64'hDEAD_BEEF);
    chk("lw_ready", 64'(b32.mem_ready), 64'd1);
    chk("lw_cnt", 64'(b32.retire_cnt), 64'd4);

    // 4: LH flushed while outstanding -> DRAIN
    issue32(2'b01, 1, 5'd8, 32'h0000_3000, 0, 3'b001, 0, 0);
    step();
    idle32();
    b32.flush = 1;
    step();
    b32.flush = 0;
    chk("drain_ready", 64'(b32.mem_ready), 64'd0);
    step();
    b32.dmem_rvalid = 1; b32.dmem_rdata = 32'h1111_2222;
    step();
    idle32();
    chk("drain_valid", 64'(b32.wb_valid), 64'd0);
    chk("drain_cnt", 64'(b32.retire_cnt), 64'd4);
    chk("drain_idle", 64'(b32.mem_ready), 64'd1);
    chk("drain_nospur", 64'(b32.wb_spurious), 64'd0);

    // 5: misaligned LH, then JAL to x0
    issue32(2'b01, 1, 5'd9, 32'h0000_1001, 0, 3'b001, 1, 32'h1234_5678);
    step();
    chk("mis_pulse", 64'(b32.wb_misalign), 64'd1);
    chk("mis_valid", 64'(b32.wb_valid), 64'd1);
    chk("mis_we", 64'(b32.wb_reg_write), 64'd0);
    issue32(2'b10, 1, 5'd0, 32'h0000_0050, 32'h0000_0104, 0, 0, 0);
    step();
    idle32();
    chk("jal_valid", 64'(b32.wb_valid), 64'd1);
    chk("jal_we", 64'(b32.wb_reg_write), 64'd0);
    chk("jal_data", 64'(b32.wb_rd_data), 64'h104);
    chk("jal_mis", 64'(b32.wb_misalign), 64'd0);
    chk("jal_cnt", 64'(b32.retire_cnt), 64'd6);

    // 6: spurious response is sticky
    b32.dmem_rvalid = 1;
    step();
    b32.dmem_rvalid = 0;
    chk("spur_set", 64'(b32.wb_spurious), 64'd1);
    step();
    chk("spur_held", 64'(b32.wb_spurious), 64'd1);

    // Flush in IDLE kills the accepted instruction
    issue32(2'b00, 1, 5'd10, 32'h0000_0AAA, 0, 0, 0, 0);
    b32.flush = 1;
    step();
    idle32();
    chk("kill_valid", 64'(b32.wb_valid), 64'd0);
    chk("kill_cnt", 64'(b32.retire_cnt), 64'd6);
    chk("kill_hold_rd", 64'(b32.wb_rd_addr), 64'd0);

    // Flush with response in the same WAIT_LOAD cycle
    issue32(2'b01, 1, 5'd12, 32'h0000_4000, 0, 3'b010, 0, 0);
    step();
    idle32();
    b32.flush = 1; b32.dmem_rvalid = 1; b32.dmem_rdata = 32'hCAFE_F00D;
    step();
    idle32();
    chk("fr_valid", 64'(b32.wb_valid), 64'd0);
    chk("fr_ready", 64'(b32.mem_ready), 64'd1);

    // Misaligned LW through the wait path
    issue32(2'b01, 1, 5'd11, 32'h0000_2002, 0, 3'b010, 0, 0);
    step();
    idle32();
    b32.dmem_rvalid = 1; b32.dmem_rdata = 32'h0102_0304;
    step();
    idle32();
    chk("wmis_pulse", 64'(b32.wb_misalign), 64'd1);
    chk("wmis_valid", 64'(b32.wb_valid), 64'd1);
    chk("wmis_we", 64'(b32.wb_reg_write), 64'd0);
    chk("wmis_cnt", 64'(b32.retire_cnt), 64'd7);

    // XLEN=64 loads
    load64(5'd2, 64'h4, 3'b110, 64'h8000_0000_0000_0000);
    step();
    chk("lwu64_data", b64.wb_rd_data, 64'h0000_0000_8000_0000);
    chk("lwu64_cnt", 64'(b64.retire_cnt), 64'd1);
    load64(5'd3, 64'h4, 3'b010, 64'h8000_0000_0000_0000);
    step();
    chk("lw64_data", b64.wb_rd_data, 64'hFFFF_FFFF_8000_0000);
    load64(5'd4, 64'h8, 3'b011, 64'h1122_3344_5566_7788);
    step();
    chk("ld64_data", b64.wb_rd_data, 64'h1122_3344_5566_7788);
    chk("ld64_we", 64'(b64.wb_reg_write), 64'd1);
    load64(5'd5, 64'h4, 3'b011, 64'h1122_3344_5566_7788);
    step();
    idle64();
    chk("ld64_mis", 64'(b64.wb_misalign), 64'd1);
    chk("ld64_mis_we", 64'(b64.wb_reg_write), 64'd0);
    chk("ld64_spur", 64'(b64.wb_spurious), 64'd0);

    // Reset while a load is outstanding
    issue32(2'b01, 1, 5'd13, 32'h0000_5000, 0, 3'b010, 0, 0);
    step();
    idle32();
    chk("pre_rst_ready", 64'(b32.mem_ready), 64'd0);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_ready", 64'(b32.mem_ready), 64'd1);
    chk("mid_rst_valid", 64'(b32.wb_valid), 64'd0);
    chk("mid_rst_cnt", 64'(b32.retire_cnt), 64'd0);
    chk("mid_rst_spur", 64'(b32.wb_spurious), 64'd0);
    issue32(2'b11, 1, 5'd6, 32'h0000_0777, 0, 0, 0, 0);
    step();
    idle32();
    chk("alias_data", 64'(b32.wb_rd_data), 64'h777);
    chk("alias_cnt", 64'(b32.retire_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
